// File: rtl/filter_ctrl_pkg.sv
// Shared types for the frame-synchronous filter select controller.
package filter_ctrl_pkg;
  localparam int H_W   = 11;
  localparam int V_W   = 10;
  localparam int PIX_W = 16;

  typedef enum logic {WAIT_SOF, RUN} state_t;

  typedef struct packed {
    logic             valid;
    logic [PIX_W-1:0] pixel;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
  } stream_t;

  // A valid beat at (0,0) marks the start of a frame.
  function automatic logic is_origin(input stream_t s);
    return s.valid && (s.h == '0) && (s.v == '0);
  endfunction
endpackage

// File: rtl/stream_mux.sv
// Combinational NUM_FILTERS-to-1 selection of one filter output stream.
module stream_mux
  import filter_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int SEL_W       = 2
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_FILTERS-1:0]       f_valid,
  input  logic [NUM_FILTERS*PIX_W-1:0] f_pixel,
  input  logic [NUM_FILTERS*H_W-1:0]   f_h_count,
  input  logic [NUM_FILTERS*V_W-1:0]   f_v_count,
  output stream_t                      out
);

  always_comb begin
    // NOTE: assigning a default before the loop covers every path, so no latch is inferred.
    out = '0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (sel == SEL_W'(i)) begin
        out.valid = f_valid[i];
        out.pixel = f_pixel[i*PIX_W +: PIX_W];
        out.h     = f_h_count[i*H_W +: H_W];
        out.v     = f_v_count[i*V_W +: V_W];
      end
    end
  end

endmodule

// File: rtl/filter_select_ctrl.sv
// Steers one of NUM_FILTERS filter streams downstream; kernel changes are
// committed at input frame start and become visible at the matching output frame start.
module filter_select_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int SEL_W       = 2,
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int RESET_SEL   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             sel_req,
  input  logic                         sel_req_valid,
  input  logic                         data_in_valid,
  input  logic [H_W-1:0]               h_count_in,
  input  logic [V_W-1:0]               v_count_in,
  input  logic [NUM_FILTERS-1:0]       f_valid,
  input  logic [NUM_FILTERS*PIX_W-1:0] f_pixel,
  input  logic [NUM_FILTERS*H_W-1:0]   f_h_count,
  input  logic [NUM_FILTERS*V_W-1:0]   f_v_count,
  output logic                         data_out_valid,
  output logic [PIX_W-1:0]             pixel_data_out,
  output logic [H_W-1:0]               h_count_out,
  output logic [V_W-1:0]               v_count_out,
  output logic [SEL_W-1:0]             active_sel,
  output logic                         switch_pending,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);
  localparam logic [H_W-1:0]   H_LAST  = H_W'(HRES - 1);
  localparam logic [V_W-1:0]   V_LAST  = V_W'(VRES - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] pend_sel, in_sel, out_sel;
  logic             pend_valid;
  logic             in_sof, out_sof, req_ok, frame_end;
  stream_t          in_stream, out_stream, fwd, out_q;

  stream_mux #(.NUM_FILTERS(NUM_FILTERS), .SEL_W(SEL_W)) u_mux_in (
    .sel       (in_sel),
    .f_valid   (f_valid),
    .f_pixel   (f_pixel),
    .f_h_count (f_h_count),
    .f_v_count (f_v_count),
    .out       (in_stream)
  );

  stream_mux #(.NUM_FILTERS(NUM_FILTERS), .SEL_W(SEL_W)) u_mux_out (
    .sel       (out_sel),
    .f_valid   (f_valid),
    .f_pixel   (f_pixel),
    .f_h_count (f_h_count),
    .f_v_count (f_v_count),
    .out       (out_stream)
  );

  assign in_sof    = data_in_valid && (h_count_in == '0) && (v_count_in == '0);
  assign out_sof   = is_origin(in_stream);
  assign req_ok    = sel_req_valid && (32'(sel_req) < NUM_FILTERS);
  assign frame_end = fwd.valid && (fwd.h == H_LAST) && (fwd.v == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_sel   <= RST_SEL;
      pend_valid <= 1'b0;
      in_sel     <= RST_SEL;
      out_sel    <= RST_SEL;
    end else begin
      // NOTE: non-blocking updates mean the commit below reads the old pend_sel,
      // so a request landing on the SOF cycle waits for the following frame.
      if (in_sof && pend_valid) begin
        in_sel     <= pend_sel;
        pend_valid <= 1'b0;
      end
      if (req_ok) begin
        pend_sel   <= sel_req;
        pend_valid <= 1'b1;
      end
      if (out_sof) out_sel <= in_sel;
    end
  end

  // On an output SOF the new select is already used for the first beat.
  always_comb begin
    state_nxt = state;
    fwd       = out_sof ? in_stream : out_stream;
    case (state)
      WAIT_SOF: begin
        if (out_sof) state_nxt = RUN;
        else         fwd.valid = 1'b0;
      end
      RUN:     ;
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_SOF;
      out_q       <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      out_q.valid <= fwd.valid;
      if (fwd.valid) begin
        out_q.pixel <= fwd.pixel;
        out_q.h     <= fwd.h;
        out_q.v     <= fwd.v;
      end
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

  assign data_out_valid = out_q.valid;
  assign pixel_data_out = out_q.pixel;
  assign h_count_out    = out_q.h;
  assign v_count_out    = out_q.v;
  assign active_sel     = out_sel;
  assign switch_pending = pend_valid || (in_sel != out_sel);

endmodule

// File: tb/tb_filter_select_ctrl.sv
// Randomised scoreboard bench for filter_select_ctrl on a small 8x4 frame
// with a fixed-latency filter bank model.
module tb_filter_select_ctrl;
  localparam int NF  = 4;
  localparam int SW  = 3;
  localparam int HR  = 8;
  localparam int VR  = 4;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SW-1:0]     sel_req = '0;
  logic              sel_req_valid = 1'b0;
  logic              data_in_valid = 1'b0;
  logic [10:0]       h_count_in = '0;
  logic [9:0]        v_count_in = '0;
  logic [NF-1:0]     f_valid;
  logic [NF*16-1:0]  f_pixel;
  logic [NF*11-1:0]  f_h_count;
  logic [NF*10-1:0]  f_v_count;
  logic              data_out_valid;
  logic [15:0]       pixel_data_out;
  logic [10:0]       h_count_out;
  logic [9:0]        v_count_out;
  logic [SW-1:0]     active_sel;
  logic              switch_pending;
  logic              frame_done;
  logic [15:0]       frame_count;

  always #5 clk = ~clk;

  filter_select_ctrl #(
    .NUM_FILTERS(NF), .SEL_W(SW), .HRES(HR), .VRES(VR), .RESET_SEL(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sel_req        (sel_req),
    .sel_req_valid  (sel_req_valid),
    .data_in_valid  (data_in_valid),
    .h_count_in     (h_count_in),
    .v_count_in     (v_count_in),
    .f_valid        (f_valid),
    .f_pixel        (f_pixel),
    .f_h_count      (f_h_count),
    .f_v_count      (f_v_count),
    .data_out_valid (data_out_valid),
    .pixel_data_out (pixel_data_out),
    .h_count_out    (h_count_out),
    .v_count_out    (v_count_out),
    .active_sel     (active_sel),
    .switch_pending (switch_pending),
    .frame_done     (frame_done),
    .frame_count    (frame_count)
  );

  // Filter bank: LAT-cycle delay of the input stream, filter i emits 0x1000*i + h.
  logic        dl_valid [LAT] = '{default: 1'b0};
  logic [10:0] dl_h     [LAT] = '{default: 11'd0};
  logic [9:0]  dl_v     [LAT] = '{default: 10'd0};

  always @(posedge clk) begin
    dl_valid[0] <= data_in_valid;
    dl_h[0]     <= h_count_in;
    dl_v[0]     <= v_count_in;
    for (int k = 1; k < LAT; k++) begin
      dl_valid[k] <= dl_valid[k-1];
      dl_h[k]     <= dl_h[k-1];
      dl_v[k]     <= dl_v[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      f_valid[i]            = dl_valid[LAT-1];
      f_pixel[i*16 +: 16]   = 16'(32'h1000 * i) + 16'(dl_h[LAT-1]);
      f_h_count[i*11 +: 11] = dl_h[LAT-1];
      f_v_count[i*10 +: 10] = dl_v[LAT-1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and reference model state
  typedef struct {
    logic [15:0]   pixel;
    logic [10:0]   h;
    logic [9:0]    v;
    logic [SW-1:0] sel;
    int            cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_cur    = 0;   // filter serving the frame currently being issued
  int          m_next   = -1;  // last in-range request since the previous frame start
  bit          synced   = 1'b0;
  logic [15:0] exp_fc   = '0;
  logic [15:0] last_pix = '0;
  logic [10:0] last_h   = '0;
  logic [9:0]  last_v   = '0;
  int          dreq [HR*VR] = '{default: -1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd_req(input int pct);
    if (int'($urandom_range(0, 99)) < pct) return int'($urandom_range(0, 7));
    return -1;
  endfunction

  // One input cycle; rsel < 0 means no request this cycle.
  task automatic step(input bit vld, input int h, input int v, input int rsel);
    @(posedge clk); #1;
    data_in_valid = vld;
    h_count_in    = vld ? 11'(h) : 11'($urandom_range(0, 2047));
    v_count_in    = vld ? 10'(v) : 10'($urandom_range(0, 1023));
    sel_req_valid = (rsel >= 0);
    sel_req       = (rsel >= 0) ? SW'(rsel) : SW'($urandom_range(0, 7));
    if (vld && h == 0 && v == 0) begin
      if (m_next >= 0) m_cur = m_next;
      m_next = -1;
      synced = 1'b1;
    end
    if (rsel >= 0 && rsel < NF) m_next = rsel;
    if (vld && synced)
      exp_q.push_back('{pixel: 16'(32'h1000 * m_cur + h), h: 11'(h), v: 10'(v),
                        sel: SW'(m_cur), cyc: cyc + LAT + 1});
  endtask

  task automatic run_frame(input int first, input int last, input int gap_pct, input int rnd_pct);
    for (int idx = first; idx <= last; idx++) begin
      for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++)
        step(1'b0, 0, 0, rnd_req(rnd_pct));
      step(1'b1, idx % HR, idx / HR, (dreq[idx] >= 0) ? dreq[idx] : rnd_req(rnd_pct));
    end
    if (last == HR*VR - 1) repeat (6) step(1'b0, 0, 0, -1);
    dreq = '{default: -1};
  endtask

  task automatic check_ctrl(input string tag, input int sp, input int as);
    check({tag, "_switch_pending"}, switch_pending, 64'(sp));
    check({tag, "_active_sel"}, active_sel, 64'(as));
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", data_out_valid, 0);
    check("rst_pixel", {pixel_data_out, h_count_out, v_count_out}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_active_sel", active_sel, 0);
    check("rst_switch_pending", switch_pending, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (data_out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", data_out_valid, 0);
          end else begin
            exp_t e;
            bit   last_beat;
            e = exp_q.pop_front();
            last_beat = (e.h == 11'(HR-1)) && (e.v == 10'(VR-1));
            if (last_beat) exp_fc = exp_fc + 16'd1;
            check("pixel", pixel_data_out, e.pixel);
            check("h_count", h_count_out, e.h);
            check("v_count", v_count_out, e.v);
            check("beat_active_sel", active_sel, e.sel);
            check("latency_cycle", cyc, e.cyc);
            check("frame_done", frame_done, last_beat);
            check("frame_count", frame_count, exp_fc);
            last_pix = e.pixel;
            last_h   = e.h;
            last_v   = e.v;
          end
        end else begin
          check("idle_frame_done", frame_done, 0);
          check("idle_hold", {pixel_data_out, h_count_out, v_count_out}, {last_pix, last_h, last_v});
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // A: request 2 mid-frame; B uses filter 2
    dreq[1*HR + 3] = 2;
    run_frame(0, HR*VR-1, 10, 0);
    check_ctrl("after_a", 1, 0);
    run_frame(0, HR*VR-1, 10, 0);
    check_ctrl("after_b", 0, 2);
    // C: requests 1 then 3; only 3 reaches D
    dreq[2] = 1;
    dreq[2*HR + 5] = 3;
    run_frame(0, HR*VR-1, 10, 0);
    check("three_frames_count", frame_count, 3);
    check_ctrl("after_c", 1, 2);
    // D: out-of-range request is ignored
    dreq[1*HR + 1] = 5;
    run_frame(0, HR*VR-1, 10, 0);
    check_ctrl("after_d", 0, 3);
    // E: request on the SOF cycle lands one frame later
    dreq[0] = 0;
    run_frame(0, HR*VR-1, 10, 0);
    check_ctrl("after_e", 1, 3);
    run_frame(0, HR*VR-1, 10, 0);
    check_ctrl("after_f", 0, 0);

    repeat (6) run_frame(0, HR*VR-1, 20, 4);

    // Reset while pixel (4,1) is in flight
    run_frame(0, 1*HR + 4, 10, 0);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    sel_req_valid = 1'b0;
    rst           = 1'b1;
    exp_q.delete();
    m_cur    = 0;
    m_next   = -1;
    synced   = 1'b0;
    exp_fc   = '0;
    last_pix = '0;
    last_h   = '0;
    last_v   = '0;
    #1;
    check_reset_outputs();
    repeat (2) step(1'b0, 0, 0, -1);
    rst = 1'b0;
    run_frame(1*HR + 5, HR*VR-1, 10, 0);
    repeat (3) run_frame(0, HR*VR-1, 15, 4);
    check("post_reset_frame_count", frame_count, 3);

    repeat (10) step(1'b0, 0, 0, -1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_select_ctrl.md
Name: filter_select_ctrl

Overview:
Frame-synchronous controller that shares one pixel stream among NUM_FILTERS parallel filter instances, each with a fixed kernel. It accepts runtime kernel-change requests, commits them only at frame boundaries, and steers the matching filter's output stream downstream. It also suppresses partial frames after reset and reports frame completion. It sits directly after the bank of filter instances and in front of the frame buffer/video output.

Parameters:
NUM_FILTERS, 4, number of filter instances in the bank (2..8)
SEL_W, 2, width of the select index (>= clog2(NUM_FILTERS))
HRES, 1280, active pixels per line
VRES, 720, active lines per frame
RESET_SEL, 0, kernel index active after reset

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous, active-high reset
sel_req  input  SEL_W  requested filter index
sel_req_valid  input  1  one-cycle strobe qualifying sel_req
data_in_valid  input  1  valid of the stream feeding the filter bank
h_count_in  input  11  h count of that stream
v_count_in  input  10  v count of that stream
f_valid  input  NUM_FILTERS  per-filter output valid
f_pixel  input  NUM_FILTERS*16  per-filter pixel, filter i at bits [16i+15:16i]
f_h_count  input  NUM_FILTERS*11  per-filter h count
f_v_count  input  NUM_FILTERS*10  per-filter v count
data_out_valid  output  1  selected stream valid
pixel_data_out  output  16  selected pixel
h_count_out  output  11  selected h count
v_count_out  output  10  selected v count
active_sel  output  SEL_W  index currently driving the output
switch_pending  output  1  a committed or requested change is not yet visible at the output
frame_done  output  1  one-cycle pulse on the last output pixel of a frame
frame_count  output  16  completed output frames, wraps at 0xFFFF to 0

Behaviour:
- Reset (async assert, sync release): all outputs 0, except active_sel = RESET_SEL. Internal pend_sel = in_sel = out_sel = RESET_SEL, pend_valid = 0, state = WAIT_SOF.
- Request capture: on sel_req_valid with sel_req < NUM_FILTERS, pend_sel <= sel_req and pend_valid <= 1. A newer request overwrites an older uncommitted one (last wins). Out-of-range requests are ignored.
- Input SOF is data_in_valid && h_count_in == 0 && v_count_in == 0. On input SOF with pend_valid: in_sel <= pend_sel and pend_valid <= 0.
- Same-cycle request and input SOF: the SOF commits the previously pending value. The new request becomes pending for the next frame.
- Output SOF is f_valid[in_sel] && f_h_count[in_sel] == 0 && f_v_count[in_sel] == 0. On output SOF: out_sel <= in_sel. The mux uses in_sel on that cycle, so the first pixel already comes from the new filter.
- Filter latency is always less than one frame time, so at most one commit is in flight.
- switch_pending = pend_valid || (in_sel != out_sel).
- FSM:
  - WAIT_SOF: data_out_valid held 0. On output SOF go to RUN and forward that beat.
  - RUN: forward f_*[out_sel] (f_*[in_sel] on output SOF cycles).
  - No other transitions. Only rst returns the FSM to WAIT_SOF.
- Output registered, latency exactly 1 cycle from filter output. When the forwarded valid is 0, pixel/h/v hold their last value.
- frame_done: asserted in the cycle data_out_valid = 1 with h_count_out == HRES-1 and v_count_out == VRES-1. frame_count increments in the same cycle, mod 2^16.
- Output invalid beats are passed as invalid. There is no backpressure; the stream is always accepted.
- Reset mid-frame: outputs drop to 0 immediately. The remainder of the frame is discarded (WAIT_SOF) and the select returns to RESET_SEL.

Decomposition:
- Package filter_ctrl_pkg holds:
  - state enum {WAIT_SOF, RUN};
  - stream struct {valid, pixel[15:0], h[10:0], v[9:0]};
  - localparams H_W = 11, V_W = 10, PIX_W = 16.
- Sub-module stream_mux: combinational NUM_FILTERS-to-1 selection of the stream struct from the packed buses. The controller registers its output.

Test Plan:
- Sim with HRES=8, VRES=4, NUM_FILTERS=4, filter i driving pixel = 16'h1000*i + h.
- Reset release -> active_sel=0, data_out_valid=0 until the first output SOF. First output is pixel 0x0000 one cycle after the filter-0 SOF beat.
- sel_req=2 strobed mid-frame -> switch_pending=1. Output stays from filter 0 through h=7, v=3. At the next output SOF, pixel_data_out=0x2000, active_sel=2, switch_pending=0.
- Requests 1 then 3 within one frame -> only 3 takes effect at the next frame. Filter 1 never drives the output.
- sel_req=5 -> ignored: switch_pending stays 0, active_sel unchanged.
- sel_req_valid on the same cycle as input SOF -> the current frame keeps the old select; the switch lands one frame later.
- Run 3 full frames -> exactly 3 frame_done pulses, each on h=7, v=3, and frame_count=3. Assert rst at pixel (4,1) -> outputs 0 immediately, no frame_done for the truncated frame.
